// File: rtl/fetch_pkg.sv
// Shared fetch-front types and constants: reset PC, BTB geometry and the BTB entry layout.
package fetch_pkg;

    localparam logic [31:0] RESET_PC    = 32'h8000_0000;
    localparam int          BTB_ENTRIES = 8;
    localparam int          BTB_IDX_W   = $clog2(BTB_ENTRIES);
    localparam int          TAG_W       = 20;
    localparam int          BTB_ENTRY_W = 1 + TAG_W + 32;

    typedef struct packed {
        logic             flag;
        logic [TAG_W-1:0] tag;
        logic [31:0]      bias;
    } btb_entry_t;

endpackage

// File: rtl/if_pc_unit_btb_regfile.sv
// BTB storage: one write port, whole-array flush, every entry read out in parallel.
module btb_regfile
    import fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [BTB_IDX_W-1:0] i_waddr,
    input  btb_entry_t           i_wdata,
    input  logic                 i_flush,
    output btb_entry_t           o_entries [BTB_ENTRIES-1:0]
);

    btb_entry_t r_entries [BTB_ENTRIES-1:0];

    // A write to the same edge as a flush wins for its own entry only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                if (i_we && (i_waddr == BTB_IDX_W'(i))) begin
                    r_entries[i] <= i_wdata;
                end else if (i_flush) begin
                    r_entries[i] <= '0;
                end
            end
        end
    end

    assign o_entries = r_entries;

endmodule

// File: rtl/if_pc_unit.sv
// Fetch-front state: PC register, refetch flag, BTB storage and the IF1->IF2 pipeline register.
module if_pc_unit
    import fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_all,
    input  logic [31:0]            newPC,
    input  logic [31:0]            IF2bias,
    input  logic                   stop_next_time,
    input  logic                   IF2_shutdown,
    input  logic                   inst_addr_misaligned,
    input  logic                   update_predictor,
    input  logic [BTB_IDX_W-1:0]   update_adr,
    input  logic [BTB_ENTRY_W-1:0] update_val,
    input  logic                   btb_flush,
    output logic [31:0]            currentpc,
    output logic                   stop_this_time,
    output btb_entry_t             predictor [BTB_ENTRIES-1:0],
    output logic [31:0]            if2_pc,
    output logic [31:0]            if2_bias,
    output logic                   if2_valid,
    output logic                   if2_misaligned
);

    logic [31:0] r_pc;
    logic        r_stop;
    logic [31:0] r_if2_pc;
    logic [31:0] r_if2_bias;
    logic        r_if2_valid;
    logic        r_if2_misaligned;
    btb_entry_t  w_update_entry;

    assign w_update_entry = btb_entry_t'(update_val);

    // A redirect must land even while the rest of the pipe is frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc   <= RESET_PC;
            r_stop <= 1'b0;
        end else if (IF2_shutdown) begin
            r_pc   <= newPC;
            r_stop <= 1'b0;
        end else if (!stall_all) begin
            r_pc   <= newPC;
            r_stop <= stop_next_time;
        end
    end

    // A squash keeps pc/bias but kills the slot, carrying only the misalignment fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if2_pc         <= '0;
            r_if2_bias       <= '0;
            r_if2_valid      <= 1'b0;
            r_if2_misaligned <= 1'b0;
        end else if (IF2_shutdown) begin
            r_if2_valid      <= 1'b0;
            r_if2_misaligned <= inst_addr_misaligned;
        end else if (!stall_all) begin
            r_if2_pc         <= r_pc;
            r_if2_bias       <= IF2bias;
            r_if2_valid      <= !r_stop;
            r_if2_misaligned <= 1'b0;
        end
    end

    btb_regfile u_btb (
        .clk       (clk),
        .rst       (rst),
        .i_we      (update_predictor),
        .i_waddr   (update_adr),
        .i_wdata   (w_update_entry),
        .i_flush   (btb_flush),
        .o_entries (predictor)
    );

    assign currentpc      = r_pc;
    assign stop_this_time = r_stop;
    assign if2_pc         = r_if2_pc;
    assign if2_bias       = r_if2_bias;
    assign if2_valid      = r_if2_valid;
    assign if2_misaligned = r_if2_misaligned;

endmodule

// File: tb/tb_if_pc_unit.sv
// Scoreboarded bench for if_pc_unit: directed scenarios plus randomized traffic against a cycle model.
module tb_if_pc_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_all;
    logic [31:0] newPC;
    logic [31:0] IF2bias;
    logic        stop_next_time;
    logic        IF2_shutdown;
    logic        inst_addr_misaligned;
    logic        update_predictor;
    logic [2:0]  update_adr;
    logic [52:0] update_val;
    logic        btb_flush;
    logic [31:0] currentpc;
    logic        stop_this_time;
    btb_entry_t  predictor [BTB_ENTRIES-1:0];
    logic [31:0] if2_pc;
    logic [31:0] if2_bias;
    logic        if2_valid;
    logic        if2_misaligned;

    if_pc_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall_all            (stall_all),
        .newPC                (newPC),
        .IF2bias              (IF2bias),
        .stop_next_time       (stop_next_time),
        .IF2_shutdown         (IF2_shutdown),
        .inst_addr_misaligned (inst_addr_misaligned),
        .update_predictor     (update_predictor),
        .update_adr           (update_adr),
        .update_val           (update_val),
        .btb_flush            (btb_flush),
        .currentpc            (currentpc),
        .stop_this_time       (stop_this_time),
        .predictor            (predictor),
        .if2_pc               (if2_pc),
        .if2_bias             (if2_bias),
        .if2_valid            (if2_valid),
        .if2_misaligned       (if2_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      pc;
        logic             stop;
        logic [31:0]      if2_pc;
        logic [31:0]      if2_bias;
        logic             if2_valid;
        logic             if2_mis;
        logic [7:0][52:0] btb;
    } snap_t;

    snap_t m;
    snap_t sb [$];
    int    total = 0;
    int    bad   = 0;

    localparam logic [52:0] V4 = {1'b0, 20'h00012, 32'h0000_0010};
    localparam logic [52:0] V5 = {1'b1, 20'hABCDE, 32'hFFFF_FFF0};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic snap_t reset_snap();
        snap_t s;
        s    = '0;
        s.pc = RESET_PC;
        return s;
    endfunction

    // Next architectural state from the current one and the inputs applied this cycle.
    function automatic snap_t advance(input snap_t c);
        snap_t n;
        n = c;
        if (IF2_shutdown) begin
            n.pc        = newPC;
            n.stop      = 1'b0;
            n.if2_valid = 1'b0;
            n.if2_mis   = inst_addr_misaligned;
        end else if (!stall_all) begin
            n.pc        = newPC;
            n.stop      = stop_next_time;
            n.if2_pc    = c.pc;
            n.if2_bias  = IF2bias;
            n.if2_valid = !c.stop;
            n.if2_mis   = 1'b0;
        end
        if (btb_flush)        n.btb = '0;
        if (update_predictor) n.btb[update_adr] = update_val;
        return n;
    endfunction

    task automatic tick();
        m = advance(m);
        sb.push_back(m);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall_all            = 1'b0;
        stop_next_time       = 1'b0;
        IF2_shutdown         = 1'b0;
        inst_addr_misaligned = 1'b0;
        update_predictor     = 1'b0;
        update_adr           = '0;
        update_val           = '0;
        btb_flush            = 1'b0;
        IF2bias              = '0;
        newPC                = m.pc + 32'd4;
    endtask

    // Monitor: every edge that has an expectation queued is compared a moment after the edge.
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_pc",        64'(currentpc),      64'(e.pc));
                chk("sb_stop",      64'(stop_this_time), 64'(e.stop));
                chk("sb_if2_pc",    64'(if2_pc),         64'(e.if2_pc));
                chk("sb_if2_bias",  64'(if2_bias),       64'(e.if2_bias));
                chk("sb_if2_valid", 64'(if2_valid),      64'(e.if2_valid));
                chk("sb_if2_mis",   64'(if2_misaligned), 64'(e.if2_mis));
                for (int i = 0; i < BTB_ENTRIES; i++) begin
                    chk($sformatf("sb_btb%0d", i), 64'(predictor[i]), 64'(e.btb[i]));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        m   = reset_snap();
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Sequential fetch out of reset
        chk("reset_pc", 64'(currentpc), 64'(32'h8000_0000));
        chk("reset_if2_valid", 64'(if2_valid), 64'(0));
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t1_pc%0d", k), 64'(currentpc), 64'(32'h8000_0000 + 32'(4 * k)));
            idle_inputs();
            IF2bias = 32'(k + 1);
            tick();
            if (k == 0) chk("t1_if2_valid_rise", 64'(if2_valid), 64'(1));
        end

        // Refetch request opens a bubble
        idle_inputs();
        stop_next_time = 1'b1;
        tick();
        chk("t2_stop", 64'(stop_this_time), 64'(1));
        idle_inputs();
        newPC = m.pc;
        tick();
        chk("t2_bubble", 64'(if2_valid), 64'(0));

        // Redirect during a stall
        idle_inputs();
        stall_all = 1'b1;
        tick();
        IF2_shutdown = 1'b1;
        newPC        = 32'h0000_1000;
        tick();
        IF2_shutdown = 1'b0;
        newPC        = 32'h0000_2000;
        chk("t3_redirect_pc", 64'(currentpc), 64'(32'h0000_1000));
        chk("t3_if2_valid", 64'(if2_valid), 64'(0));
        tick();
        chk("t3_pc_held", 64'(currentpc), 64'(32'h0000_1000));

        // BTB writes, with and without stall
        idle_inputs();
        update_predictor = 1'b1;
        update_adr       = 3'd5;
        update_val       = V4;
        tick();
        chk("t4_btb5", 64'(predictor[5]), 64'(V4));
        chk("t4_btb4", 64'(predictor[4]), 64'(0));
        idle_inputs();
        stall_all        = 1'b1;
        update_predictor = 1'b1;
        update_adr       = 3'd6;
        update_val       = V4;
        tick();
        chk("t4_btb6_stalled", 64'(predictor[6]), 64'(V4));

        // Flush racing a write
        idle_inputs();
        btb_flush        = 1'b1;
        update_predictor = 1'b1;
        update_adr       = 3'd2;
        update_val       = V5;
        tick();
        chk("t5_btb2", 64'(predictor[2]), 64'(V5));
        chk("t5_btb5", 64'(predictor[5]), 64'(0));
        chk("t5_btb6", 64'(predictor[6]), 64'(0));

        // Misaligned redirect token
        idle_inputs();
        IF2_shutdown         = 1'b1;
        inst_addr_misaligned = 1'b1;
        newPC                = m.pc;
        tick();
        chk("t6_mis", 64'(if2_misaligned), 64'(1));
        chk("t6_valid", 64'(if2_valid), 64'(0));
        idle_inputs();
        tick();
        chk("t6_mis_clear", 64'(if2_misaligned), 64'(0));

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            stall_all            = ($urandom_range(0, 3) == 0);
            IF2_shutdown         = ($urandom_range(0, 9) == 0);
            inst_addr_misaligned = IF2_shutdown && ($urandom_range(0, 1) == 1);
            stop_next_time       = ($urandom_range(0, 6) == 0);
            update_predictor     = ($urandom_range(0, 2) == 0);
            update_adr           = 3'($urandom_range(0, 7));
            update_val           = {21'($urandom), $urandom};
            btb_flush            = ($urandom_range(0, 19) == 0);
            IF2bias              = $urandom;
            if ($urandom_range(0, 4) == 0) newPC = $urandom & 32'hFFFF_FFFC;
            tick();
        end

        // Asynchronous reset in the middle of a cycle
        idle_inputs();
        update_predictor = 1'b1;
        update_adr       = 3'd7;
        update_val       = V5;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t7_pc", 64'(currentpc), 64'(RESET_PC));
        chk("t7_stop", 64'(stop_this_time), 64'(0));
        chk("t7_if2_pc", 64'(if2_pc), 64'(0));
        chk("t7_if2_bias", 64'(if2_bias), 64'(0));
        chk("t7_if2_valid", 64'(if2_valid), 64'(0));
        chk("t7_if2_mis", 64'(if2_misaligned), 64'(0));
        for (int i = 0; i < BTB_ENTRIES; i++) begin
            chk($sformatf("t7_btb%0d", i), 64'(predictor[i]), 64'(0));
        end
        m = reset_snap();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            tick();
        end
        chk("t7_restart_pc", 64'(currentpc), 64'(32'h8000_000C));

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drain", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
